izhikevich_scheduler: RTL

//  Time-multiplexes one Izhikevich update datapath across NEURONS neurons. Holds per-neuron
//  (v, w) state, issues one neuron per slot to the external core, applies threshold reset
//  (v<=c, w<=w_next+d) and writes back. One start pulse = one simulation timestep over all neurons.

---
 rtl/izhikevich_scheduler_pkg.sv | 40 ++++
 rtl/izhikevich_scheduler_if.sv | 24 ++
 rtl/izhikevich_scheduler_state_mem.sv | 38 +++
 rtl/izhikevich_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/izhikevich_scheduler_pkg.sv
// Shared fixed-point types, FSM encoding and saturating add
// for the time-multiplexed Izhikevich neuron scheduler.
package izh_pkg;

  localparam int FIXED_W = 32;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_e;

  localparam fixed_t FIXED_MAX =
    {1'b0, {(FIXED_W-1){1'b1}}};
  localparam fixed_t FIXED_MIN =
    {1'b1, {(FIXED_W-1){1'b0}}};

  function automatic fixed_t sat_add(
    input fixed_t a,
    input fixed_t b
  );
    logic signed [FIXED_W:0] s;
    s = {a[FIXED_W-1], a} + {b[FIXED_W-1], b};
    if (s[FIXED_W] != s[FIXED_W-1])
      sat_add = s[FIXED_W] ? FIXED_MIN : FIXED_MAX;
    else
      sat_add = s[FIXED_W-1:0];
  endfunction

endpackage

// File: rtl/izhikevich_scheduler_if.sv
// Operand/result bus between the scheduler and the
// external Izhikevich update core (plus current lookup).
interface izhikevich_scheduler_if #(
  parameter int N  = 32,
  parameter int IW = 3
);
  logic [IW-1:0] cur_idx;
  logic [N-1:0]  cur_i;
  logic [N-1:0]  core_v;
  logic [N-1:0]  core_w;
  logic [N-1:0]  core_i;
  logic [N-1:0]  core_v_next;
  logic [N-1:0]  core_w_next;

  modport master (
    output cur_idx, core_v, core_w, core_i,
    input  cur_i, core_v_next, core_w_next
  );

  modport slave (
    input  cur_idx, core_v, core_w, core_i,
    output cur_i, core_v_next, core_w_next
  );
endinterface

// File: rtl/izhikevich_scheduler_state_mem.sv
// Per-neuron (v, w) register file: one sync write port,
// one async read port, cleared by async reset.
module izh_state_mem
  import izh_pkg::*;
#(
  parameter int NEURONS = 8,
  parameter int IW      = $clog2(NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  fixed_t        wv,
  input  fixed_t        ww,
  input  logic [IW-1:0] raddr,
  output fixed_t        rv,
  output fixed_t        rw
);

  fixed_t r_v [NEURONS];
  fixed_t r_w [NEURONS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEURONS; i++) begin
        r_v[i] <= '0;
        r_w[i] <= '0;
      end
    end else if (we) begin
      r_v[waddr] <= wv;
      r_w[waddr] <= ww;
    end
  end

  assign rv = r_v[raddr];
  assign rw = r_w[raddr];

endmodule

// File: rtl/izhikevich_scheduler.sv
// Izhikevich neuron scheduler: one shared core, NEURONS slots
// per timestep. Optional spike counter: IZH_SPIKE_COUNT_EN.
module izhikevich_scheduler
  import izh_pkg::*;
#(
  parameter int N        = FIXED_W,
  parameter int Q        = 16,
  parameter int NEURONS  = 8,
  parameter int CORE_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       init_we,
  input  logic [$clog2(NEURONS)-1:0] init_idx,
  input  fixed_t                     init_v,
  input  fixed_t                     init_w,
  input  fixed_t                     v_th,
  input  fixed_t                     c,
  input  fixed_t                     d,
  output logic                       busy,
  output logic                       done,
  output logic                       spike_valid,
  output logic [$clog2(NEURONS)-1:0] spike_idx,
  output logic [$clog2(NEURONS):0]   spike_count,
  izhikevich_scheduler_if.master     core
);

  localparam int IW = $clog2(NEURONS);
  localparam int CW = IW + 1;
  localparam int LW = $clog2(CORE_LAT + 1);

  if (N != FIXED_W || Q >= N ||
      NEURONS < 2 || CORE_LAT < 1) begin : g_bad
    $error("izhikevich_scheduler: bad params");
  end

  state_e        r_state;
  logic [IW-1:0] r_idx;
  logic [LW-1:0] r_wait;
  fixed_t        r_vth, r_c, r_d;
  fixed_t        r_core_v, r_core_w, r_core_i;

  fixed_t        w_rv, w_rw, w_vn, w_wn;
  fixed_t        w_nv, w_nw, w_wv, w_ww;
  logic          w_start, w_last, w_spike, w_we;
  logic [IW-1:0] w_waddr;

  assign w_vn    = core.core_v_next;
  assign w_wn    = core.core_w_next;
  assign w_start = (r_state == IDLE) && start;
  assign w_last  = r_idx == IW'(NEURONS - 1);
  assign w_spike = (r_state == WRITE) &&
                   (w_vn >= r_vth);
  assign w_nv    = w_spike ? r_c : w_vn;
  assign w_nw    = w_spike ? sat_add(w_wn, r_d)
                           : w_wn;

  // Init writes share the port; only legal in IDLE.
  assign w_we    = (r_state == WRITE) ||
                   ((r_state == IDLE) && init_we);
  assign w_waddr = (r_state == WRITE) ? r_idx : init_idx;
  assign w_wv    = (r_state == WRITE) ? w_nv : init_v;
  assign w_ww    = (r_state == WRITE) ? w_nw : init_w;

  izh_state_mem #(
    .NEURONS (NEURONS),
    .IW      (IW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_waddr),
    .wv    (w_wv),
    .ww    (w_ww),
    .raddr (r_idx),
    .rv    (w_rv),
    .rw    (w_rw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_wait   <= '0;
      r_vth    <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_core_v <= '0;
      r_core_w <= '0;
      r_core_i <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_start) begin
          r_state <= ISSUE;
          r_idx   <= '0;
          r_vth   <= v_th;
          r_c     <= c;
          r_d     <= d;
        end
        ISSUE: begin
          r_core_v <= w_rv;
          r_core_w <= w_rw;
          r_core_i <= core.cur_i;
          r_wait   <= LW'(1);
          r_state  <= WAIT;
        end
        // Operands reach the core one cycle after ISSUE.
        WAIT: begin
          if (r_wait == LW'(CORE_LAT))
            r_state <= WRITE;
          else
            r_wait <= r_wait + LW'(1);
        end
        WRITE: begin
          if (w_last) begin
            r_state <= DONE;
            r_idx   <= '0;
          end else begin
            r_state <= ISSUE;
            r_idx   <= r_idx + IW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy         = (r_state == ISSUE) ||
                        (r_state == WAIT)  ||
                        (r_state == WRITE);
  assign done         = r_state == DONE;
  assign spike_valid  = w_spike;
  assign spike_idx    = w_spike ? r_idx : '0;
  assign core.cur_idx = r_idx;
  assign core.core_v  = r_core_v;
  assign core.core_w  = r_core_w;
  assign core.core_i  = r_core_i;

`ifdef IZH_SPIKE_COUNT_EN
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_start)
      r_cnt <= '0;
    else if (w_spike && r_cnt != CW'(NEURONS))
      r_cnt <= r_cnt + CW'(1);
  end

  assign spike_count = r_cnt;
`else
  assign spike_count = '0;
`endif

endmodule
